// File: rtl/seven_segment_scan_controller_if.sv
// Bundle between the seven-segment interface block and the scan controller:
// packed digit codes and dot enables in, multiplexed display drive out.
interface seven_segment_scan_controller_if;
    logic        en;
    logic [31:0] digit;
    logic [7:0]  en_dot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    // Producer side: supplies codes and enable, observes the display drive.
    modport master (
        output en,
        output digit,
        output en_dot,
        input  an,
        input  seg,
        input  dp,
        input  frame_done
    );

    // Scan controller side.
    modport slave (
        input  en,
        input  digit,
        input  en_dot,
        output an,
        output seg,
        output dp,
        output frame_done
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode seven-segment
// display. A snapshot of the digit codes and dot enables is taken once per
// frame so a frame never mixes old and new values; each digit slot starts with
// a dark interval so the anode switch never overlaps a cathode change.
module seven_segment_scan_controller #(
    parameter int SLOT_CYC  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic                         clk,
    input  logic                         rst,
    seven_segment_scan_controller_if.slave bus
);

    localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;

    // Counter landmarks within a slot.
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(SLOT_CYC - 1);

    // Dark drive levels (all active-low lines released).
    localparam logic [7:0] AN_DARK  = 8'hFF;
    localparam logic [6:0] SEG_DARK = 7'h7F;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        LOAD  = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [CW-1:0] cnt;
    logic [31:0] snap_digit;
    logic [7:0]  snap_dot;

    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    // Per-digit view of the snapshot and the lit pattern for the current slot.
    logic [3:0]  snap_code [8];
    logic [6:0]  snap_seg  [8];
    logic [7:0]  lit_an;
    logic [6:0]  lit_seg;
    logic        lit_dp;

    // 4-bit code to active-low {g,f,e,d,c,b,a}; code F blanks the segments.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] pattern;
        case (code)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = SEG_DARK;
        endcase
        return pattern;
    endfunction

    // Slice the snapshot into per-digit codes and pre-decode each one.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign snap_code[gi] = snap_digit[4*gi +: 4];
            assign snap_seg[gi]  = decode(snap_code[gi]);
        end
    endgenerate

    // Drive pattern for the slot selected by idx; only registered state feeds it.
    always_comb begin
        lit_an  = ~(8'b1 << idx);
        lit_seg = snap_seg[idx];
        lit_dp  = ~snap_dot[idx];
    end

    // Scan FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= OFF;
            idx        <= 3'd0;
            cnt        <= '0;
            snap_digit <= 32'hFFFF_FFFF;
            snap_dot   <= 8'h00;
            an         <= AN_DARK;
            seg        <= SEG_DARK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // Dark and no pulse unless the next state says otherwise.
            an         <= AN_DARK;
            seg        <= SEG_DARK;
            dp         <= 1'b1;
            frame_done <= 1'b0;

            if (!bus.en) begin
                // Disable wins from any state, including LOAD: no snapshot,
                // no end-of-frame pulse, scan restarts from digit 0 later.
                state <= OFF;
                idx   <= 3'd0;
                cnt   <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state <= LOAD;
                        idx   <= 3'd0;
                        cnt   <= '0;
                    end

                    LOAD: begin
                        state      <= BLANK;
                        idx        <= 3'd0;
                        cnt        <= '0;
                        snap_digit <= bus.digit;
                        snap_dot   <= bus.en_dot;
                    end

                    BLANK: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_BLANK_LAST) begin
                            state <= SHOW;
                            an    <= lit_an;
                            seg   <= lit_seg;
                            dp    <= lit_dp;
                        end
                    end

                    SHOW: begin
                        if (cnt == CNT_SLOT_LAST) begin
                            cnt <= '0;
                            if (idx == 3'd7) begin
                                // Frame complete: re-snapshot and flag it.
                                state      <= LOAD;
                                idx        <= 3'd0;
                                frame_done <= 1'b1;
                            end else begin
                                state <= BLANK;
                                idx   <= idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            an  <= lit_an;
                            seg <= lit_seg;
                            dp  <= lit_dp;
                        end
                    end

                    default: begin
                        state <= OFF;
                        idx   <= 3'd0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.an         = an;
    assign bus.seg        = seg;
    assign bus.dp         = dp;
    assign bus.frame_done = frame_done;

endmodule

// File: doc/seven_segment_scan_controller.md
# seven_segment_scan_controller

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. Takes the 32-bit packed digit codes and 8-bit dot enables produced by the seven-segment interface block and drives them onto the display. It captures a tear-free snapshot once per frame, steps through the eight digits with a fixed dwell and an anti-ghosting blank interval, and decodes 4-bit codes to segment patterns.

## Interface
- SLOT_CYC, default 100000: clock cycles per digit slot. Legal range: >= 2.
- BLANK_CYC, default 2000: blanked cycles at the start of each slot. Legal range: 1 <= BLANK_CYC < SLOT_CYC.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset. Asynchronous, active-high.
- en  in  1  display enable. While low, the display is dark and the scan is held off.
- digit  in  32  digit codes; digit i is bits [4i+3:4i], and digit 0 is the rightmost.
- en_dot  in  8  decimal-point enable; bit i controls digit i.
- an  out  8  anode selects, active-low; an[i] drives digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse marking the end of a full 8-digit scan.

## Operation
- States:
  - OFF: dark.
  - LOAD: one cycle; snapshot taken.
  - BLANK: slot i, dark.
  - SHOW: slot i, digit lit.
- Counters: 3-bit slot index `idx`; cycle counter `cnt` of width $clog2(SLOT_CYC).
- Transitions:
  - OFF -> LOAD when en=1.
  - LOAD -> BLANK with idx=0, cnt=0. The snapshot registers load digit and en_dot at this edge.
  - BLANK -> SHOW when cnt reaches BLANK_CYC-1.
  - SHOW -> BLANK(idx+1) when cnt reaches SLOT_CYC-1 and idx<7.
  - SHOW -> LOAD when cnt reaches SLOT_CYC-1 and idx=7.
  - Any state -> OFF on the next edge with en=0. No frame_done is issued in this case.
- `cnt` counts 0..SLOT_CYC-1 within a slot and clears at each slot boundary.
- Dark output values: an=8'hFF, seg=7'h7F, dp=1. These are driven in OFF, LOAD and BLANK.
- SHOW outputs:
  - an = ~(8'b1 << idx).
  - seg = decode(snapshot code idx).
  - dp = ~snapshot en_dot[idx].
- Decode table, active-low hex:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06
  - F: blank (7F).
- Code F blanks the segments only; dp is still honoured.
- digit and en_dot changes mid-frame have no effect until the next LOAD.
- frame_done = 1 only during a LOAD cycle entered from SHOW of idx 7. It is never asserted for a LOAD entered from OFF.

## Timing
- Outputs are flops. Their values correspond to the current state cycle, with no combinational path from inputs.
- Reset values (held asynchronously while rst=1): state OFF, idx=0, cnt=0, snapshot=32'hFFFFFFFF / 8'h00, an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Startup sequence, with en=1 when rst falls:
  - Cycle 1 after deassertion: LOAD.
  - Cycles 2..1+BLANK_CYC: slot 0 blank.
  - Cycle 2+BLANK_CYC: an=8'hFE.
- Frame period = 8*SLOT_CYC + 1 cycles. Per-digit lit time = SLOT_CYC - BLANK_CYC cycles.
- Anti-ghosting: an is never active for two digits at once, and is never active during the cycle seg changes between digits. Every digit change passes through >= BLANK_CYC dark cycles.
- en falling: the display goes dark at the first edge with en=0.
- en rising: LOAD in the next cycle, and the scan restarts at idx 0.
- rst asserted mid-slot: outputs go dark immediately, without waiting for a clock edge.
- en toggling during LOAD: en=0 wins, giving OFF at the next edge, and the snapshot is not updated.

## Test plan
Unless stated, tests use SLOT_CYC=8 and BLANK_CYC=2.

1. Reset/idle. Assert rst with en=0, then release -> an=FF, seg=7F, dp=1, frame_done=0 for 50 cycles.
2. Full scan.
   - Stimulus: digit=32'hFEDC3210, en_dot=8'h05, en=1.
   - Required per-slot lit values:
     - slot0: an=FE, seg=40, dp=0
     - slot1: an=FD, seg=79, dp=1
     - slot2: an=FB, seg=24, dp=0
     - slot3: an=F7, seg=30
     - slot4: seg=46; slot5: seg=21; slot6: seg=06
     - slot7: an=7F, seg=7F
   - Each slot lit for exactly 6 cycles. frame_done pulses once every 65 cycles.
3. Snapshot hold. Change digit from 32'h00000000 to 32'h11111111 during slot 3 -> slots 3–7 still show seg=40; the next frame shows seg=79.
4. Channel display. digit=32'hFFFFFFF2, en_dot=8'h80 -> only slot0 lights segments (seg=24); slot7 shows an=7F, seg=7F, dp=0.
5. Enable abort. Drop en during SHOW of slot 4 -> dark on the next edge, and no frame_done. Raise en again -> LOAD, then slot0 lights after 3 cycles.
6. Async reset mid-SHOW -> an=FF within the same cycle, before the next clk edge. Check that no two an bits are ever low simultaneously, using a continuous assertion.
